// File: rtl/uart_tx_fifo.sv
// UART transmitter with a small transmit FIFO, runtime parity/stop configuration
// and back-to-back framing. Bit timing comes from an external one-cycle baud tick.
module uart_tx_fifo #(
    parameter int DATA_BITS  = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int LEVEL_W    = $clog2(FIFO_DEPTH + 1)
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 tx_baud,
    input  logic                 tx_enable,
    input  logic [1:0]           parity_mode,
    input  logic                 stop_bits,
    input  logic                 in_valid,
    input  logic [DATA_BITS-1:0] in_data,
    output logic                 in_ready,
    output logic [LEVEL_W-1:0]   fifo_level,
    output logic                 busy,
    output logic                 tx_done,
    output logic                 tx
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = $clog2(DATA_BITS);
    localparam logic [CNT_W-1:0]   LAST_BIT   = CNT_W'(DATA_BITS - 1);
    localparam logic [LEVEL_W-1:0] FULL_LEVEL = LEVEL_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    // Write side: a word is accepted when in_valid && in_ready (valid/ready handshake).
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    state_t               state, state_n;
    logic [DATA_BITS-1:0] shreg, shreg_n;
    logic [CNT_W-1:0]     bit_cnt, bit_cnt_n;
    logic                 stop_cnt, stop_cnt_n;
    logic                 stop_lat, stop_lat_n;
    logic                 par_en, par_en_n;
    logic                 par_bit, par_bit_n;
    logic                 tx_q, tx_n;
    logic                 done_q, done_n;
    logic                 can_pop;

    assign in_ready = (fifo_level != FULL_LEVEL);
    assign push     = in_valid && in_ready;
    assign head     = mem[rd_ptr];
    // Uses the registered level, so a word written on a tick cycle waits for the next tick.
    assign can_pop  = tx_enable && (fifo_level != '0);

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   fifo_level <= fifo_level + 1'b1;
                2'b01:   fifo_level <= fifo_level - 1'b1;
                default: fifo_level <= fifo_level;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state    <= IDLE;
            shreg    <= '0;
            bit_cnt  <= '0;
            stop_cnt <= 1'b0;
            stop_lat <= 1'b0;
            par_en   <= 1'b0;
            par_bit  <= 1'b0;
            tx_q     <= 1'b1;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            shreg    <= shreg_n;
            bit_cnt  <= bit_cnt_n;
            stop_cnt <= stop_cnt_n;
            stop_lat <= stop_lat_n;
            par_en   <= par_en_n;
            par_bit  <= par_bit_n;
            tx_q     <= tx_n;
            done_q   <= done_n;
        end
    end

    always_comb begin
        state_n    = state;
        shreg_n    = shreg;
        bit_cnt_n  = bit_cnt;
        stop_cnt_n = stop_cnt;
        stop_lat_n = stop_lat;
        par_en_n   = par_en;
        par_bit_n  = par_bit;
        tx_n       = tx_q;
        done_n     = 1'b0;
        pop        = 1'b0;

        if (tx_baud) begin
            case (state)
                IDLE: begin
                    if (can_pop) begin
                        pop        = 1'b1;
                        shreg_n    = head;
                        par_en_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                        par_bit_n  = (^head) ^ (parity_mode == 2'b10);
                        stop_lat_n = stop_bits;
                        tx_n       = 1'b0;
                        state_n    = START;
                    end
                end
                START: begin
                    tx_n      = shreg[0];
                    bit_cnt_n = '0;
                    state_n   = DATA;
                end
                DATA: begin
                    if (bit_cnt == LAST_BIT) begin
                        stop_cnt_n = 1'b0;
                        if (par_en) begin
                            tx_n    = par_bit;
                            state_n = PARITY;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = STOP;
                        end
                    end else begin
                        shreg_n   = shreg >> 1;
                        tx_n      = shreg[1];
                        bit_cnt_n = bit_cnt + 1'b1;
                    end
                end
                PARITY: begin
                    tx_n       = 1'b1;
                    stop_cnt_n = 1'b0;
                    state_n    = STOP;
                end
                STOP: begin
                    if (stop_cnt == stop_lat) begin
                        done_n = 1'b1;
                        // Next word goes straight into its start bit with no idle period.
                        if (can_pop) begin
                            pop        = 1'b1;
                            shreg_n    = head;
                            par_en_n   = (parity_mode == 2'b01) || (parity_mode == 2'b10);
                            par_bit_n  = (^head) ^ (parity_mode == 2'b10);
                            stop_lat_n = stop_bits;
                            tx_n       = 1'b0;
                            state_n    = START;
                        end else begin
                            tx_n    = 1'b1;
                            state_n = IDLE;
                        end
                    end else begin
                        stop_cnt_n = stop_cnt + 1'b1;
                    end
                end
                default: begin
                    tx_n    = 1'b1;
                    state_n = IDLE;
                end
            endcase
        end
    end

    assign busy    = (state != IDLE);
    assign tx_done = done_q;
    assign tx      = tx_q;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo: an 8-bit and a 7-bit instance share clock, reset,
// baud tick and configuration; each frame is checked bit by bit against hand-written strings.
module tb_uart_tx_fifo;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       reset_n;
    logic       tx_baud;
    logic       tx_enable;
    logic [1:0] parity_mode;
    logic       stop_bits;
    logic       in_valid8;
    logic [7:0] in_data8;
    logic       in_valid7;
    logic [6:0] in_data7;

    logic       in_ready8, busy8, tx_done8, tx8;
    logic [2:0] fifo_level8;
    logic       in_ready7, busy7, tx_done7, tx7;
    logic [2:0] fifo_level7;

    int n_checks = 0;
    int n_fail   = 0;

    uart_tx_fifo #(.DATA_BITS(8), .FIFO_DEPTH(4)) dut8 (
        .clock(clock), .reset_n(reset_n), .tx_baud(tx_baud), .tx_enable(tx_enable),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .in_valid(in_valid8),
        .in_data(in_data8), .in_ready(in_ready8), .fifo_level(fifo_level8),
        .busy(busy8), .tx_done(tx_done8), .tx(tx8)
    );

    uart_tx_fifo #(.DATA_BITS(7), .FIFO_DEPTH(4)) dut7 (
        .clock(clock), .reset_n(reset_n), .tx_baud(tx_baud), .tx_enable(tx_enable),
        .parity_mode(parity_mode), .stop_bits(stop_bits), .in_valid(in_valid7),
        .in_data(in_data7), .in_ready(in_ready7), .fifo_level(fifo_level7),
        .busy(busy7), .tx_done(tx_done7), .tx(tx7)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    function automatic logic [31:0] sel_tx(input bit u7);
        return 32'(u7 ? tx7 : tx8);
    endfunction
    function automatic logic [31:0] sel_busy(input bit u7);
        return 32'(u7 ? busy7 : busy8);
    endfunction
    function automatic logic [31:0] sel_done(input bit u7);
        return 32'(u7 ? tx_done7 : tx_done8);
    endfunction
    function automatic logic [31:0] sel_level(input bit u7);
        return 32'(u7 ? fifo_level7 : fifo_level8);
    endfunction

    // Called at a falling edge; returns at the falling edge after the tick cycle.
    task automatic tick();
        tx_baud = 1'b1;
        @(negedge clock);
        tx_baud = 1'b0;
    endtask

    task automatic gap(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push8(input logic [7:0] d);
        in_valid8 = 1'b1;
        in_data8  = d;
        @(negedge clock);
        in_valid8 = 1'b0;
    endtask

    task automatic start_frame(input string tag, input bit u7, input int exp_level);
        tick();
        check({tag, " start tx"}, sel_tx(u7), 0);
        check({tag, " start busy"}, sel_busy(u7), 1);
        check({tag, " start level"}, sel_level(u7), exp_level);
        gap(15);
    endtask

    // s holds the line value after each tick in time order; s[0] is the start bit.
    task automatic run_body(input string tag, input bit u7, input string s);
        for (int i = 1; i < s.len(); i++) begin
            tick();
            check($sformatf("%s bit%0d", tag, i), sel_tx(u7), (s.getc(i) == "1") ? 1 : 0);
            gap(15);
        end
    endtask

    task automatic end_frame(input string tag, input bit u7, input bit b2b, input int exp_level);
        tick();
        check({tag, " done"}, sel_done(u7), 1);
        check({tag, " end tx"}, sel_tx(u7), b2b ? 0 : 1);
        check({tag, " end busy"}, sel_busy(u7), b2b ? 1 : 0);
        check({tag, " end level"}, sel_level(u7), exp_level);
        @(negedge clock);
        check({tag, " done pulse"}, sel_done(u7), 0);
        gap(14);
    endtask

    initial begin
        reset_n     = 1'b0;
        tx_baud     = 1'b0;
        tx_enable   = 1'b0;
        parity_mode = 2'b01;
        stop_bits   = 1'b0;
        in_valid8   = 1'b0;
        in_data8    = '0;
        in_valid7   = 1'b0;
        in_data7    = '0;

        gap(2);
        check("rst tx", 32'(tx8), 1);
        check("rst busy", 32'(busy8), 0);
        check("rst done", 32'(tx_done8), 0);
        check("rst level", 32'(fifo_level8), 0);
        check("rst ready", 32'(in_ready8), 1);
        check("rst tx7", 32'(tx7), 1);
        reset_n = 1'b1;
        gap(2);
        tx_enable = 1'b1;

        // Word written on a tick cycle must not start a frame on that tick
        in_valid8 = 1'b1;
        in_data8  = 8'hA5;
        tx_baud   = 1'b1;
        @(negedge clock);
        in_valid8 = 1'b0;
        tx_baud   = 1'b0;
        check("push on tick busy", 32'(busy8), 0);
        check("push on tick level", 32'(fifo_level8), 1);
        check("push on tick tx", 32'(tx8), 1);
        gap(15);

        // 0xA5, even parity, one stop
        start_frame("even", 1'b0, 0);
        run_body("even", 1'b0, "01010010101");
        end_frame("even", 1'b0, 1'b0, 0);

        tick();
        check("empty tick busy", 32'(busy8), 0);
        check("empty tick tx", 32'(tx8), 1);
        gap(15);

        // 0xA5, odd parity
        parity_mode = 2'b10;
        push8(8'hA5);
        start_frame("odd", 1'b0, 0);
        run_body("odd", 1'b0, "01010010111");
        end_frame("odd", 1'b0, 1'b0, 0);

        // 0xA5, no parity, two stop bits
        parity_mode = 2'b00;
        stop_bits   = 1'b1;
        push8(8'hA5);
        start_frame("none2", 1'b0, 0);
        run_body("none2", 1'b0, "01010010111");
        end_frame("none2", 1'b0, 1'b0, 0);
        stop_bits = 1'b0;

        // Fill while disabled, then drain back-to-back
        parity_mode = 2'b01;
        tx_enable   = 1'b0;
        push8(8'h01);
        check("fill level1", 32'(fifo_level8), 1);
        push8(8'h02);
        check("fill level2", 32'(fifo_level8), 2);
        push8(8'h03);
        check("fill level3", 32'(fifo_level8), 3);
        check("fill ready3", 32'(in_ready8), 1);
        push8(8'h04);
        check("fill level4", 32'(fifo_level8), 4);
        check("full ready", 32'(in_ready8), 0);
        in_valid8 = 1'b1;
        in_data8  = 8'h05;
        gap(3);
        check("held off level", 32'(fifo_level8), 4);
        check("held off ready", 32'(in_ready8), 0);
        in_valid8 = 1'b0;
        tick();
        check("disabled tick busy", 32'(busy8), 0);
        check("disabled tick level", 32'(fifo_level8), 4);
        gap(15);
        tx_enable = 1'b1;
        start_frame("b2b f1", 1'b0, 3);
        run_body("b2b f1", 1'b0, "01000000011");
        end_frame("b2b f1", 1'b0, 1'b1, 2);
        run_body("b2b f2", 1'b0, "00100000011");
        end_frame("b2b f2", 1'b0, 1'b1, 1);
        run_body("b2b f3", 1'b0, "01100000001");
        end_frame("b2b f3", 1'b0, 1'b1, 0);
        run_body("b2b f4", 1'b0, "00010000011");
        end_frame("b2b f4", 1'b0, 1'b0, 0);

        // Parity change mid-frame affects only the next frame
        push8(8'hA5);
        push8(8'h01);
        start_frame("pchg f1", 1'b0, 1);
        parity_mode = 2'b10;
        run_body("pchg f1", 1'b0, "01010010101");
        end_frame("pchg f1", 1'b0, 1'b1, 0);
        run_body("pchg f2", 1'b0, "01000000001");
        end_frame("pchg f2", 1'b0, 1'b0, 0);

        // 7-bit instance, 0x7F even parity
        parity_mode = 2'b01;
        in_valid7   = 1'b1;
        in_data7    = 7'h7F;
        @(negedge clock);
        in_valid7 = 1'b0;
        start_frame("d7", 1'b1, 0);
        run_body("d7", 1'b1, "0111111111");
        end_frame("d7", 1'b1, 1'b0, 0);

        // Asynchronous reset during the 4th data bit
        push8(8'hA5);
        push8(8'h5A);
        start_frame("rst mid", 1'b0, 1);
        run_body("rst mid", 1'b0, "01010");
        #2;
        reset_n = 1'b0;
        #1;
        check("async rst tx", 32'(tx8), 1);
        check("async rst busy", 32'(busy8), 0);
        check("async rst level", 32'(fifo_level8), 0);
        check("async rst ready", 32'(in_ready8), 1);
        @(negedge clock);
        reset_n = 1'b1;
        gap(2);
        tick();
        check("post rst busy", 32'(busy8), 0);
        check("post rst tx", 32'(tx8), 1);
        gap(15);
        push8(8'h01);
        start_frame("post rst", 1'b0, 0);
        run_body("post rst", 1'b0, "01000000011");
        end_frame("post rst", 1'b0, 1'b0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
